// File: rtl/ewh_pkg.sv
// Shared definitions for the laser burst transmitter.
//   state_e    : transmitter FSM states
//   FRAME_BITS : bit-times per frame (start + data + stop)
//   DATA_W     : data bits per frame, sent MSB first
//   cnt_w()    : counter width helper that never returns zero
package ewh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_COOLDOWN
  } state_e;

  localparam int FRAME_BITS = 6;
  localparam int DATA_W     = 4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, plus one extra flop
// for rising-edge detection. The rise pulse is registered.
//   clock : system clock
//   reset : synchronous, active-low
//   in    : raw asynchronous input
//   level : synchronised level, time-aligned with rise
//   rise  : one-cycle pulse on a low-to-high transition of the synchronised level
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, s3_q, rise_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  // s3 holds the same sample that produced rise_q, so the two stay aligned
  assign level = s3_q;
  assign rise  = rise_q;

endmodule

// File: rtl/laser_burst_tx.sv
// Laser burst transmitter: a rising edge on the glove flex sensor fires
// FRAMES frames of {start=1, 4 data bits MSB first, stop=0}, each bit
// BIT_CYCLES clocks long, followed by a COOLDOWN_CYCLES quiet period.
//   clock      : system clock
//   reset      : synchronous, active-low
//   flex       : raw asynchronous flex-sensor level
//   enable     : high permits new bursts
//   glove_code : identity code, latched when a burst is accepted
//   laser      : registered laser drive
//   busy       : high from first laser cycle until cooldown ends
//   burst_done : one-cycle pulse on the first cooldown cycle
//   shot_count : bursts started since reset, wraps at 16 bits
module laser_burst_tx
  import ewh_pkg::*;
#(
  parameter int BIT_CYCLES      = 2500,
  parameter int FRAMES          = 4,
  parameter int COOLDOWN_CYCLES = 250000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flex,
  input  logic              enable,
  input  logic [DATA_W-1:0] glove_code,
  output logic              laser,
  output logic              busy,
  output logic              burst_done,
  output logic [15:0]       shot_count
);

  localparam int BW = cnt_w(BIT_CYCLES);
  localparam int CW = cnt_w(COOLDOWN_CYCLES + 1);
  localparam int IW = cnt_w(DATA_W);
  localparam int FW = 4;

  state_e              state_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [IW-1:0]       bit_idx_q;
  logic [FW-1:0]       frame_q;
  logic [CW-1:0]       cool_q;
  logic [DATA_W-1:0]   code_q;
  logic [15:0]         shot_q;
  logic                laser_q, busy_q, done_q;
  logic                flex_lvl, flex_rise, trig, bit_end;

  sync_edge_detect u_sync (
    .clock (clock),
    .reset (reset),
    .in    (flex),
    .level (flex_lvl),
    .rise  (flex_rise)
  );

  // rise always implies level; the AND states that a trigger is a fresh high level
  assign trig    = flex_rise & flex_lvl;
  assign bit_end = (bit_cnt_q == BW'(BIT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      cool_q    <= '0;
      code_q    <= '0;
      shot_q    <= '0;
      laser_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE && state_q != ST_COOLDOWN)
        bit_cnt_q <= bit_end ? '0 : bit_cnt_q + BW'(1);
      case (state_q)
        ST_IDLE: begin
          if (trig && enable) begin
            state_q   <= ST_START;
            laser_q   <= 1'b1;
            busy_q    <= 1'b1;
            code_q    <= glove_code;
            shot_q    <= shot_q + 16'd1;
            bit_cnt_q <= '0;
            frame_q   <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            laser_q   <= code_q[DATA_W-1];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == IW'(DATA_W - 1)) begin
              state_q <= ST_STOP;
              laser_q <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + IW'(1);
              // next bit down from MSB: index DATA_W-1-(bit_idx_q+1)
              laser_q   <= code_q[IW'(DATA_W - 2) - bit_idx_q];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (frame_q == FW'(FRAMES - 1)) begin
              state_q <= ST_COOLDOWN;
              done_q  <= 1'b1;
              cool_q  <= '0;
            end else begin
              state_q <= ST_START;
              frame_q <= frame_q + FW'(1);
              laser_q <= 1'b1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (cool_q == CW'(COOLDOWN_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cool_q <= cool_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign laser      = laser_q;
  assign busy       = busy_q;
  assign burst_done = done_q;
  assign shot_count = shot_q;

endmodule

// File: tb/tb_laser_burst_tx.sv
module tb_laser_burst_tx;
  localparam int BC = 4, FR = 2, CD = 10;
  localparam int TOTAL = FR * 6 * BC;

  logic clock = 1'b0, reset = 1'b0, flex = 1'b0, enable = 1'b0;
  logic [3:0] glove_code = 4'h0;
  logic laser, busy, burst_done;
  logic [15:0] shot_count;

  laser_burst_tx #(.BIT_CYCLES(BC), .FRAMES(FR), .COOLDOWN_CYCLES(CD)) dut (
    .clock(clock), .reset(reset), .flex(flex), .enable(enable),
    .glove_code(glove_code), .laser(laser), .busy(busy),
    .burst_done(burst_done), .shot_count(shot_count)
  );

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;
  int laser_hi = 0, done_cnt = 0, busy_cnt = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: t_m is the position within the burst+cooldown
  // window (-1 when idle); flex history f1..f4 = samples at previous edges.
  int         t_m = -1;
  logic [15:0] shot_m = 16'h0;
  logic [3:0]  code_m = 4'h0;
  logic        f1 = 0, f2 = 0, f3 = 0, f4 = 0;
  bit          preload_req = 0, started = 0;

  always @(posedge clock) begin
    started = 1;
    if (!reset) begin
      t_m = -1; shot_m = 16'h0; code_m = 4'h0;
      f1 = 0; f2 = 0; f3 = 0; f4 = 0;
    end else begin
      // flex settled high for the sample three edges ago, low the one before
      if (t_m < 0 && f3 && !f4 && enable) begin
        t_m = 0; shot_m = shot_m + 16'd1; code_m = glove_code;
      end else if (t_m >= 0) begin
        t_m++;
        if (t_m == TOTAL + CD) t_m = -1;
      end
      f4 = f3; f3 = f2; f2 = f1; f1 = flex;
      if (preload_req) begin shot_m = 16'hFFFF; preload_req = 0; end
    end
  end

  function automatic logic exp_laser(input int t, input logic [3:0] c);
    int b;
    if (t < 0 || t >= TOTAL) return 1'b0;
    b = (t / BC) % 6;
    if (b == 0) return 1'b1;
    if (b == 5) return 1'b0;
    return c[4 - b];
  endfunction

  always @(negedge clock) begin
    if (started) begin
      check("laser", {15'h0, laser}, {15'h0, exp_laser(t_m, code_m)});
      check("busy", {15'h0, busy}, {15'h0, logic'(t_m >= 0)});
      check("burst_done", {15'h0, burst_done}, {15'h0, logic'(t_m == TOTAL)});
      check("shot_count", shot_count, shot_m);
      if (laser) laser_hi++;
      if (burst_done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic clr();
    laser_hi = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_laser", {15'h0, laser}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_shot", shot_count, 16'h0);
    reset = 1'b1; enable = 1'b1;

    // 1010 burst, re-edges during data and during cooldown are ignored
    glove_code = 4'b1010; clr();
    for (int i = 0; i < 100; i++) begin
      case (i)
        0: flex = 1'b1; 18: flex = 1'b0; 24: flex = 1'b1; 30: flex = 1'b0;
        54: flex = 1'b1; 58: flex = 1'b0;
        default: ;
      endcase
      tick();
    end
    check("s1_laser_hi", 16'(laser_hi), 16'd24);
    check("s1_done_pulses", 16'(done_cnt), 16'd1);
    check("s1_busy_cycles", 16'(busy_cnt), 16'd58);
    check("s1_shot", shot_count, 16'd1);

    // enable low: edge discarded
    reset = 1'b0; repeat (2) tick(); reset = 1'b1; enable = 1'b0; clr();
    for (int i = 0; i < 70; i++) begin
      if (i == 0) flex = 1'b1;
      if (i == 30) flex = 1'b0;
      tick();
    end
    check("s3_laser_hi", 16'(laser_hi), 16'd0);
    check("s3_busy", 16'(busy_cnt), 16'd0);
    check("s3_shot", shot_count, 16'd0);

    // reset mid-burst, nothing resumes after release
    enable = 1'b1; glove_code = 4'(($urandom));
    for (int i = 0; i < 80; i++) begin
      case (i)
        0: flex = 1'b1; 19: reset = 1'b0;
        20: begin reset = 1'b1; flex = 1'b0; clr(); end
        default: ;
      endcase
      tick();
      if (i == 19) check("s4_laser_after_rst", {15'h0, laser}, 16'h0);
    end
    check("s4_laser_hi", 16'(laser_hi), 16'd0);
    check("s4_shot", shot_count, 16'd0);

    // code change mid-burst does not affect transmitted bits
    glove_code = 4'hF; clr();
    for (int i = 0; i < 80; i++) begin
      case (i)
        0: flex = 1'b1; 3: flex = 1'b0; 10: glove_code = 4'h0;
        default: ;
      endcase
      tick();
    end
    check("s6_laser_hi", 16'(laser_hi), 16'd40);
    check("s6_shot", shot_count, 16'd1);

    // shot_count wrap from 0xFFFF
    force dut.shot_q = 16'hFFFF; preload_req = 1;
    tick();
    release dut.shot_q;
    tick();
    check("s5_preload", shot_count, 16'hFFFF);
    for (int i = 0; i < 80; i++) begin
      if (i == 0) flex = 1'b1;
      if (i == 5) flex = 1'b0;
      tick();
    end
    check("s5_wrap", shot_count, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) flex = ~flex;
      enable = ($urandom_range(9) != 0);
      glove_code = 4'($urandom);
      reset = ($urandom_range(399) != 0);
      tick();
    end
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
